// File: rtl/imem_pkg.sv
// Shared instruction-memory constants, loader state encoding and lane helpers.
// Also reused by the instruction memory itself.
package imem_pkg;

    localparam int IMEM_ADDR_W      = 8;
    localparam int IMEM_DEPTH_BYTES = 1 << IMEM_ADDR_W;
    localparam int IMEM_BYTE_W      = 8;
    localparam int IMEM_WORD_W      = 32;
    localparam int IMEM_LANES       = IMEM_WORD_W / IMEM_BYTE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        CHK  = 2'd2,
        DONE = 2'd3
    } imem_state_e;

    function automatic logic [IMEM_LANES-1:0] lane_bit(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader-side bus interfaces: the incoming program byte stream and the
// outgoing word-write port toward the instruction memory.
interface imem_stream_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_in, output byte_valid, input byte_ready);
    modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

interface imem_wr_if
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;

    modport master (output mem_we, output mem_addr, output mem_wdata, output mem_be);
    modport slave  (input mem_we, input mem_addr, input mem_wdata, input mem_be);
endinterface

// File: rtl/imem_byte_packer.sv
// Packs accepted bytes into little-endian words; emits a registered write one
// cycle after a word fills or the final (possibly partial) word is flushed.
module imem_byte_packer
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    input  logic [ADDR_W-1:0] in_idx,
    input  logic              in_last,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_wdata,
    output logic [3:0]        out_be
);

    logic [31:0] acc_data;
    logic [3:0]  acc_be;
    logic [1:0]  lane;
    logic [31:0] merged_data;
    logic [3:0]  merged_be;

    assign lane = in_idx[1:0];

    always_comb begin
        merged_data = acc_data | ({24'b0, in_byte} << {lane, 3'b000});
        merged_be   = acc_be | lane_bit(lane);
    end

    // Accumulator is cleared after every emit so untouched lanes read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_data  <= '0;
            acc_be    <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_wdata <= '0;
            out_be    <= '0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                if (lane == 2'd3 || in_last) begin
                    out_valid <= 1'b1;
                    out_addr  <= {in_idx[ADDR_W-1:2], 2'b00};
                    out_wdata <= merged_data;
                    out_be    <= merged_be;
                    acc_data  <= '0;
                    acc_be    <= '0;
                end else begin
                    acc_data  <= merged_data;
                    acc_be    <= merged_be;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory byte-stream loader; holds the core until a clean load.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | after reset, waiting for start, core held
// RECV  | accepting len program bytes
// CHK   | accepting the checksum byte (IMEM_LOADER_CHECKSUM_EN only)
// DONE  | load finished; err/cpu_hold report the outcome, start reloads
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W      = IMEM_ADDR_W,
    parameter int DEPTH_BYTES = IMEM_DEPTH_BYTES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [ADDR_W:0] len,
    imem_stream_if.slave  stream,
    imem_wr_if.master     wr,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_RECV = 2'(RECV);
    localparam logic [1:0] ST_CHK  = 2'(CHK);
    localparam logic [1:0] ST_DONE = 2'(DONE);
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH_BYTES);

    logic [1:0]      state;
    logic [ADDR_W:0] len_q;
    logic [ADDR_W:0] count;
    logic            accept;
    logic            data_accept;
    logic            last_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      xsum;
`endif

    logic              pk_valid;
    logic [ADDR_W-1:0] pk_addr;
    logic [31:0]       pk_wdata;
    logic [3:0]        pk_be;

    assign stream.byte_ready = (state == ST_RECV) || (state == ST_CHK);
    assign accept      = stream.byte_valid && stream.byte_ready;
    assign data_accept = accept && (state == ST_RECV);
    assign last_data   = (count == len_q - 1'b1);

    assign busy = (state == ST_RECV) || (state == ST_CHK);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            count    <= '0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xsum     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (len == '0) begin
                            state    <= ST_DONE;
                            err      <= 1'b0;
                            cpu_hold <= 1'b0;
                        end else if (len > MAX_LEN) begin
                            state    <= ST_DONE;
                            err      <= 1'b1;
                            cpu_hold <= 1'b1;
                        end else begin
                            state    <= ST_RECV;
                            len_q    <= len;
                            count    <= '0;
                            err      <= 1'b0;
                            cpu_hold <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            xsum     <= '0;
`endif
                        end
                    end
                end
                ST_RECV: begin
                    if (accept) begin
                        count <= count + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xsum  <= xsum ^ stream.byte_in;
                        if (last_data) state <= ST_CHK;
`else
                        if (last_data) begin
                            state    <= ST_DONE;
                            cpu_hold <= 1'b0;
                        end
`endif
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (accept) begin
                        state    <= ST_DONE;
                        err      <= (stream.byte_in != xsum);
                        cpu_hold <= (stream.byte_in != xsum);
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The final write is issued by the packer regardless of the state change above.
    imem_byte_packer #(.ADDR_W(ADDR_W)) u_packer (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (data_accept),
        .in_byte   (stream.byte_in),
        .in_idx    (count[ADDR_W-1:0]),
        .in_last   (last_data),
        .out_valid (pk_valid),
        .out_addr  (pk_addr),
        .out_wdata (pk_wdata),
        .out_be    (pk_be)
    );

    assign wr.mem_we    = pk_valid;
    assign wr.mem_addr  = pk_addr;
    assign wr.mem_wdata = pk_wdata;
    assign wr.mem_be    = pk_be;

endmodule
